// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory
// request at a time and captures each returned word, with its PC, into a
// single-entry output register that feeds decode. Redirects from the branch
// and jump logic retarget the PC and squash any fetch still in flight.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | one dead cycle after reset before the first request
// REQ    | request presented whenever the output register can take a word
// WAIT   | request accepted, waiting for the single outstanding response
module if_stage #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;

  logic                  slot_free;
  logic                  req_valid;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  redirect_lsb_unused;

  // Redirect targets are word aligned; the two low bits carry no information.
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Request-side signals: a request may only go out when the returning word
  // is guaranteed a place in the output register.
  always_comb begin
    slot_free       = !inst_valid_q || !stall;
    req_valid       = (state_q == S_REQ) && slot_free;
    handshake       = req_valid && imem_req_ready;
    pc_inc          = pc_q + ADDR_WIDTH'(4);
    redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  end

  // Next-state logic for the FSM, PC, drop flag and output register;
  // a redirect overrides whatever the FSM would otherwise do this cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q && stall;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    if (redirect_valid) begin
      pc_d         = redirect_target;
      inst_valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
        S_REQ: begin
          // The old address already left with this handshake, so its
          // response must be thrown away when it arrives.
          if (handshake) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
        end
        S_REQ: begin
          if (handshake) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            // With drop set the PC already holds the redirect target.
            if (!drop_q) begin
              inst_d       = imem_resp_inst;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_inc;
            end
            drop_d  = 1'b0;
            state_d = S_REQ;
          end
        end
        default: begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the RISC-V core. It holds the program counter and issues one instruction-memory request at a time through a valid/ready handshake. Each returned instruction word is captured into a single-entry output register together with its PC, and that register drives the decode stage (control unit, immediate generator, ALU control). Branch and jump targets resolved downstream redirect the PC and flush any fetch still in flight.

## Interface
- `ADDR_WIDTH`, default 32: PC and memory address width.
- `INST_WIDTH`, default 32: instruction word width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req_valid`  out  1  fetch request present.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  ADDR_WIDTH  fetch address, equal to the current PC.
- `imem_resp_valid`  in  1  instruction word returned this cycle.
- `imem_resp_inst`  in  INST_WIDTH  returned instruction word.
- `redirect_valid`  in  1  taken branch or jal resolved downstream.
- `redirect_pc`  in  ADDR_WIDTH  redirect target.
- `stall`  in  1  decode cannot consume the output register this cycle.
- `inst_valid`  out  1  output register holds a live instruction.
- `inst`  out  INST_WIDTH  fetched instruction.
- `inst_pc`  out  ADDR_WIDTH  address of `inst`.

## Operation
- **Reset values:** pc = RESET_PC, state = IDLE, drop = 0, inst_valid = 0, inst = 0, inst_pc = 0, imem_req_valid = 0.
- **Slot free:** the condition `!inst_valid || !stall`.
- **Consume:** the output register is consumed when `inst_valid && !stall`. If no new word is written that cycle, inst_valid clears at the edge.
- **FSM, IDLE:** always goes to REQ on the next edge, so there is one dead cycle after reset.
- **FSM, REQ:**
  - `imem_req_valid = slot free`.
  - When valid && ready, go to WAIT.
- **FSM, WAIT:**
  - `imem_req_valid = 0`.
  - When imem_resp_valid arrives with drop = 0: write inst, inst_pc <= pc, inst_valid <= 1, pc <= pc + 4, then go to REQ.
  - When it arrives with drop = 1: discard the word, clear drop, go to REQ. pc is unchanged because it already holds the redirect target.
- **Redirect** has priority over everything else in the same cycle:
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}, so the low two bits are ignored.
  - inst_valid <= 0, which flushes the output register.
  - In REQ with no handshake this cycle: stay in REQ. Next cycle the request uses the new pc.
  - In REQ with a handshake this same cycle: the old address has gone out, so go to WAIT with drop = 1.
  - In WAIT with no response: stay in WAIT and set drop = 1.
  - In WAIT with a response this same cycle: discard the word, go to REQ, drop = 0.
- **Outstanding requests:** at most one. A request is issued only when the slot is free, so a response never finds the output register occupied.
- **PC arithmetic:** pc + 4 wraps modulo 2^ADDR_WIDTH. For example, 32'hFFFF_FFFC is followed by 32'h0000_0000.
- **Unsolicited response:** imem_resp_valid outside WAIT is ignored.

## Timing
- **Request outputs:** imem_req_valid and imem_req_addr are combinational from state, pc and the slot-free condition.
- **Address stability:** imem_req_addr is stable while valid && !ready. The one exception is a redirect, which may change the address before acceptance.
- **Latency:** handshake at edge N and response at edge N+k gives inst_valid high from cycle N+k+1. The next request is raised in cycle N+k+1.
- **Peak throughput:** one instruction per 2 cycles when memory responds one cycle after acceptance.
- **Stall behaviour:** while inst_valid && stall, the block holds inst and inst_pc and keeps imem_req_valid low.
- **Reset mid-transaction:** all state returns to reset values immediately (asynchronous). A response arriving afterwards is ignored, since the FSM is in IDLE or REQ.

## Test plan
- **Reset release, ready tied high, responses one cycle later with words 0x00000013, 0x00100093, 0x00200113:**
  - first request at cycle 2 with addr 0x0;
  - outputs (inst_pc, inst): (0x0, 0x00000013), (0x4, 0x00100093), (0x8, 0x00200113);
  - one output every 2 cycles.
- **Stall:** hold stall high for 5 cycles while inst_valid is high.
  - inst and inst_pc stay constant and imem_req_valid stays 0.
  - After stall drops, the next request goes out for addr inst_pc + 4.
- **Redirect in WAIT:** assert redirect_valid with redirect_pc 0x100 while a fetch of 0x8 is outstanding.
  - The 0x8 response is dropped and inst_valid stays 0.
  - The next request is for 0x100, and the first output has inst_pc 0x100.
- **Simultaneous events:**
  - Redirect to 0x200 in the same cycle as a REQ handshake for 0xC: the 0xC response is discarded and the next request is for 0x200.
  - Redirect to 0x300 in the same cycle as a valid response: the word is discarded and the next address is 0x300.
- **Wrap and alignment:**
  - RESET_PC = 0xFFFFFFFC fetches 0xFFFFFFFC, then 0x00000000.
  - redirect_pc = 0x103 produces a fetch of 0x100.
- **Asynchronous reset while in WAIT:** outputs go to their reset values without waiting for a clock edge. A late imem_resp_valid produces no inst_valid, and fetching restarts at RESET_PC.
